instr_mem_loader: RTL and testbench

//  Upstream program loader for the instruction memory (c_mem) of core_main: takes 32-bit instruction

---
 rtl/instr_mem_loader.sv | 202 ++++++++++++++++++++
 tb/tb_instr_mem_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Streams instruction words into c_mem from address 0, optionally reads each back,
// and releases the core (core_rst=1) only after the final word is committed.
module instr_mem_loader #(
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 256,
  parameter int VERIFY  = 1,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              mem_request,
  output logic              mem_we_re,
  output logic [3:0]        mem_masking,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_w_data,
  input  logic              mem_valid,
  input  logic [31:0]       mem_r_data,
  output logic              core_rst,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  // state  | meaning
  // IDLE   | after reset, core held, waiting for start
  // GET    | in_ready=1, waiting for a stream word
  // WR     | write request outstanding
  // RD     | read-back request outstanding
  // DONE   | load complete, core released
  // ERR    | verify mismatch, timeout or overflow; core held
  typedef enum logic [2:0] {S_IDLE, S_GET, S_WR, S_RD, S_DONE, S_ERR} state_t;

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD  = TMO_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0]  DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [3:0]        mask_q, mask_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       word_q, word_d;
  logic              last_q, last_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              core_rst_q, core_rst_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   count_inc;
  logic              commit;
  logic              fail;

  always_comb begin
    state_d    = state_q;
    in_ready_d = in_ready_q;
    req_d      = req_q;
    we_d       = we_q;
    mask_d     = mask_q;
    addr_d     = addr_q;
    word_d     = word_q;
    last_d     = last_q;
    tmo_d      = tmo_q;
    core_rst_d = core_rst_q;
    done_d     = done_q;
    error_d    = error_q;
    count_d    = count_q;
    count_inc  = count_q + 1'b1;
    commit     = 1'b0;
    fail       = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_GET;
          in_ready_d = 1'b1;
          addr_d     = '0;
          count_d    = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          core_rst_d = 1'b0;
        end
      end
      S_GET: begin
        if (in_valid && in_ready_q) begin
          word_d     = in_data;
          last_d     = in_last;
          in_ready_d = 1'b0;
          req_d      = 1'b1;
          we_d       = 1'b1;
          mask_d     = 4'hF;
          tmo_d      = TMO_LOAD;
          state_d    = S_WR;
        end
      end
      S_WR: begin
        if (mem_valid) begin
          if (VERIFY != 0) begin
            // Request stays up and turns into the read-back of the same address.
            we_d    = 1'b0;
            mask_d  = 4'h0;
            tmo_d   = TMO_LOAD;
            state_d = S_RD;
          end else begin
            commit = 1'b1;
          end
        end else if (tmo_q == '0) begin
          fail = 1'b1;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      S_RD: begin
        if (mem_valid) begin
          if (mem_r_data != word_q) fail = 1'b1;
          else                      commit = 1'b1;
        end else if (tmo_q == '0) begin
          fail = 1'b1;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (commit) begin
      req_d   = 1'b0;
      we_d    = 1'b0;
      mask_d  = 4'h0;
      count_d = count_inc;
      // Address saturates at the last word rather than wrapping back to 0.
      if (count_inc < DEPTH_CNT) addr_d = addr_q + 1'b1;
      if (last_q) begin
        state_d    = S_DONE;
        done_d     = 1'b1;
        core_rst_d = 1'b1;
      end else if (count_inc == DEPTH_CNT) begin
        fail = 1'b1;
      end else begin
        state_d    = S_GET;
        in_ready_d = 1'b1;
      end
    end

    if (fail) begin
      state_d = S_ERR;
      error_d = 1'b1;
      req_d   = 1'b0;
      we_d    = 1'b0;
      mask_d  = 4'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      mask_q     <= 4'h0;
      addr_q     <= '0;
      word_q     <= '0;
      last_q     <= 1'b0;
      tmo_q      <= '0;
      core_rst_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      req_q      <= req_d;
      we_q       <= we_d;
      mask_q     <= mask_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      last_q     <= last_d;
      tmo_q      <= tmo_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      error_q    <= error_d;
      count_q    <= count_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign mem_request = req_q;
  assign mem_we_re   = we_q;
  assign mem_masking = mask_q;
  assign mem_address = addr_q;
  assign mem_w_data  = word_q;
  assign core_rst    = core_rst_q;
  assign done        = done_q;
  assign error       = error_q;
  assign word_count  = count_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: a behavioural memory logs every completed access and
// each load is checked against the expected write/read-back sequence.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready, in_last;
  logic [31:0] in_data;
  logic        mem_request, mem_we_re, mem_valid;
  logic [3:0]  mem_masking;
  logic [7:0]  mem_address;
  logic [31:0] mem_w_data, mem_r_data;
  logic        core_rst, done, error;
  logic [8:0]  word_count;

  instr_mem_loader #(.ADDR_W(8), .DEPTH(4), .VERIFY(1), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .mem_request(mem_request), .mem_we_re(mem_we_re),
    .mem_masking(mem_masking), .mem_address(mem_address), .mem_w_data(mem_w_data),
    .mem_valid(mem_valid), .mem_r_data(mem_r_data), .core_rst(core_rst), .done(done),
    .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  mask;
    int          cyc;
  } txn_t;

  txn_t        log_q[$];
  logic [31:0] mem_arr [256];
  int          n_chk = 0, n_pass = 0, cyc = 0;
  logic        stall = 1'b0, force_valid = 1'b1, fixed_lat = 1'b1, corrupt_en = 1'b0;
  logic [7:0]  corrupt_addr = 8'd0;

  // Memory: answers each request after 1..3 cycles with a single-cycle mem_valid.
  initial begin : memory
    logic pending, mv;
    int   wait_cnt;
    txn_t t;
    pending = 1'b0; wait_cnt = 0;
    mem_valid = 1'b0; mem_r_data = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      mv = 1'b0;
      if (pending && !mem_request) pending = 1'b0;
      if (pending) begin
        if (wait_cnt <= 1) begin
          mv = 1'b1; pending = 1'b0;
          t.we = mem_we_re; t.addr = mem_address; t.mask = mem_masking; t.cyc = cyc;
          if (mem_we_re) begin
            mem_arr[mem_address] = mem_w_data;
            t.data = mem_w_data;
          end else begin
            mem_r_data = (corrupt_en && mem_address == corrupt_addr) ? 32'hDEADBEEF
                                                                      : mem_arr[mem_address];
            t.data = mem_r_data;
          end
          log_q.push_back(t);
        end else begin
          wait_cnt--;
        end
      end else if (mem_request && !stall) begin
        pending  = 1'b1;
        wait_cnt = fixed_lat ? 1 : int'($urandom_range(1, 3));
      end
      mem_valid = mv | force_valid;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] d, input logic l, input int gap,
                           input int bound, output logic ok);
    repeat (gap) step();
    in_valid = 1'b1; in_data = d; in_last = l; ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      step();
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_end(input int bound);
    for (int i = 0; i < bound && !(done || error); i++) step();
    chk("end_reached", 64'(done | error), 64'd1);
  endtask

  // Expected sequence for n committed words: write i then read-back i, starting at address 0.
  task automatic check_load(input logic [31:0] w[$], input int n, input logic [31:0] bad_rd);
    chk("log_len", 64'(log_q.size()), 64'(2 * n));
    for (int i = 0; i < n && (2 * i + 1) < log_q.size(); i++) begin
      chk($sformatf("wr%0d", i),
          64'({log_q[2*i].we, log_q[2*i].addr, log_q[2*i].data, log_q[2*i].mask}),
          64'({1'b1, 8'(i), w[i], 4'hF}));
      chk($sformatf("rd%0d", i),
          64'({log_q[2*i+1].we, log_q[2*i+1].addr, log_q[2*i+1].mask}),
          64'({1'b0, 8'(i), 4'h0}));
      chk($sformatf("rd%0d_data", i), 64'(log_q[2*i+1].data), 64'(w[i]));
    end
  endtask

  initial begin : main
    logic [31:0] w[$];
    logic        ok;
    int          cnt, n;
    logic        early_err;

    rst = 1'b0; start = 1'b0; in_valid = 1'b1; in_data = 32'h1234_5678; in_last = 1'b1;
    step(); step();
    chk("rst_req", 64'({mem_request, mem_we_re, mem_masking}), 64'd0);
    chk("rst_flags", 64'({in_ready, core_rst, done, error}), 64'd0);
    chk("rst_addr_cnt", 64'({mem_address, word_count, mem_w_data}), 64'd0);
    rst = 1'b1; force_valid = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    step();

    // Three-word program with memory echo.
    w = '{32'h00500093, 32'h00A00113, 32'h002081B3};
    log_q.delete();
    pulse_start();
    for (int i = 0; i < 3; i++) push_word(w[i], i == 2, 0, 40, ok);
    wait_end(60);
    chk("prog_done", 64'({done, core_rst, error}), 64'b110);
    chk("prog_count", 64'(word_count), 64'd3);
    check_load(w, 3, 32'h0);
    if (log_q.size() >= 3) chk("cycles_per_word", 64'(log_q[2].cyc - log_q[0].cyc), 64'd5);

    // Read-back mismatch on word 1.
    pulse_start();
    chk("restart_from_done", 64'({done, core_rst, in_ready, word_count}), 64'({3'b001, 9'd0}));
    log_q.delete();
    corrupt_en = 1'b1; corrupt_addr = 8'd1;
    push_word(w[0], 1'b0, 0, 40, ok);
    push_word(w[1], 1'b0, 0, 40, ok);
    push_word(w[2], 1'b1, 0, 30, ok);
    chk("no_accept_after_err", 64'(ok), 64'd0);
    chk("mismatch_flags", 64'({error, core_rst, done}), 64'b100);
    chk("mismatch_count", 64'(word_count), 64'd1);
    chk("mismatch_log_len", 64'(log_q.size()), 64'd4);
    if (log_q.size() >= 4) chk("mismatch_rd_data", 64'(log_q[3].data), 64'h0DEADBEEF);
    repeat (10) step();
    chk("err_quiet", 64'({log_q.size() == 4, mem_request}), 64'b10);
    corrupt_en = 1'b0;
    pulse_start();
    chk("err_cleared", 64'({error, core_rst, in_ready}), 64'b001);
    log_q.delete();
    w = '{32'hCAFE0001, 32'hCAFE0002};
    push_word(w[0], 1'b0, 0, 40, ok);
    push_word(w[1], 1'b1, 0, 40, ok);
    wait_end(60);
    chk("reload_done", 64'({done, word_count}), 64'({1'b1, 9'd2}));
    check_load(w, 2, 32'h0);

    // Timeout on the first write.
    stall = 1'b1;
    pulse_start();
    push_word(32'h1111_2222, 1'b1, 0, 40, ok);
    cnt = 0; early_err = 1'b0;
    while (mem_request && cnt < 40) begin
      if (error) early_err = 1'b1;
      cnt++;
      step();
    end
    chk("timeout_req_cycles", 64'(cnt), 64'd15);
    chk("timeout_flags", 64'({early_err, error, mem_request, core_rst}), 64'b0100);
    stall = 1'b0;

    // Overflow: DEPTH=4, no last.
    pulse_start();
    log_q.delete();
    w = '{};
    for (int i = 0; i < 5; i++) w.push_back($urandom);
    for (int i = 0; i < 4; i++) push_word(w[i], 1'b0, 0, 40, ok);
    push_word(w[4], 1'b0, 0, 40, ok);
    chk("ovf_5th_refused", 64'(ok), 64'd0);
    wait_end(20);
    chk("ovf_flags", 64'({error, done, core_rst}), 64'b100);
    chk("ovf_count", 64'(word_count), 64'd4);
    check_load(w, 4, 32'h0);

    // Stalled stream and start pulses during WR.
    pulse_start();
    log_q.delete();
    w = '{32'hA5A5_0000, 32'h5A5A_1111, 32'h0F0F_2222};
    push_word(w[0], 1'b0, 0, 40, ok);
    pulse_start();
    push_word(w[1], 1'b0, 7, 40, ok);
    chk("in_wr_state", 64'({mem_request, mem_we_re}), 64'b11);
    pulse_start();
    push_word(w[2], 1'b1, 7, 40, ok);
    wait_end(60);
    chk("stall_done", 64'({done, error, word_count}), 64'({2'b10, 9'd3}));
    check_load(w, 3, 32'h0);

    // Randomized loads with random latency and gaps.
    fixed_lat = 1'b0;
    for (int it = 0; it < 6; it++) begin
      n = int'($urandom_range(1, 4));
      w = '{};
      for (int i = 0; i < n; i++) w.push_back($urandom);
      pulse_start();
      log_q.delete();
      for (int i = 0; i < n; i++) push_word(w[i], i == n - 1, int'($urandom_range(0, 3)), 60, ok);
      wait_end(80);
      chk($sformatf("rand%0d_end", it), 64'({done, core_rst, error, word_count}), 64'({3'b110, 9'(n)}));
      check_load(w, n, 32'h0);
    end
    fixed_lat = 1'b1;

    // Reset while a write is outstanding.
    stall = 1'b1;
    pulse_start();
    push_word(32'h7777_8888, 1'b1, 0, 40, ok);
    chk("pre_rst_req", 64'(mem_request), 64'd1);
    rst = 1'b0;
    step();
    chk("midrst_req", 64'({mem_request, mem_we_re, mem_masking, in_ready}), 64'd0);
    chk("midrst_flags", 64'({core_rst, done, error, word_count, mem_address}), 64'd0);
    rst = 1'b1; stall = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
